// File: rtl/vvm_cfg_sched.sv
// Configuration scheduler for vvm_dsp: shadow registers are applied atomically on a
// result_strobe frame boundary, followed by a datapath flush and a settling window.
module vvm_cfg_sched #(
   parameter int          N_CH            = 4,
   parameter int          RST_CYC         = 2,
   parameter int          N_SETTLE        = 4,
   parameter logic [12:0] CIC_PERIOD_INIT = 13'd10,
   parameter logic [3:0]  CIC_SHIFT_INIT  = 4'd7,
   parameter logic [5:0]  IIR_SHIFT_INIT  = 6'd4
) (
   input  logic                 sample_clk,
   input  logic                 sample_rst_n,
   input  logic                 cfg_we,
   input  logic [2:0]           cfg_addr,
   input  logic [31:0]          cfg_wdata,
   input  logic                 result_strobe,
   output logic [32*N_CH-1:0]   ftw,
   output logic [12:0]          cic_period,
   output logic [3:0]           cic_shift,
   output logic [5:0]           iir_shift,
   output logic                 dsp_rst,
   output logic                 busy,
   output logic                 meas_valid,
   output logic [7:0]           commit_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PEND   = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_SETTLE = 2'd3
   } state_t;

   localparam logic [3:0] FLUSH_LOAD  = 4'(RST_CYC - 1);
   localparam logic [7:0] SETTLE_LOAD = 8'(N_SETTLE);

   logic [31:0]        r_sh_ftw [N_CH];
   logic [12:0]        r_sh_period;
   logic [3:0]         r_sh_cic_shift;
   logic [5:0]         r_sh_iir_shift;

   state_t             r_state;
   logic [3:0]         r_flush_cnt;
   logic [7:0]         r_settle_cnt;
   logic               r_pend_req;
   logic               r_from_commit;
   logic [32*N_CH-1:0] r_ftw;
   logic [12:0]        r_cic_period;
   logic [3:0]         r_cic_shift;
   logic [5:0]         r_iir_shift;
   logic               r_dsp_rst;
   logic               r_meas_valid;
   logic [7:0]         r_commit_cnt;

   logic               w_commit;

   assign w_commit = cfg_we && (cfg_addr == 3'd7);

   // Shadow register file, written from the bus in any state
   always_ff @(posedge sample_clk or negedge sample_rst_n) begin
      if (!sample_rst_n) begin
         for (int n = 0; n < N_CH; n++) begin
            r_sh_ftw[n] <= 32'd0;
         end
         r_sh_period    <= CIC_PERIOD_INIT;
         r_sh_cic_shift <= CIC_SHIFT_INIT;
         r_sh_iir_shift <= IIR_SHIFT_INIT;
      end else if (cfg_we) begin
         case (cfg_addr)
            3'd4: r_sh_period    <= cfg_wdata[12:0];
            3'd5: r_sh_cic_shift <= cfg_wdata[3:0];
            3'd6: r_sh_iir_shift <= cfg_wdata[5:0];
            3'd7: begin
            end
            default: begin
               for (int n = 0; n < N_CH; n++) begin
                  if (cfg_addr == 3'(n)) begin
                     r_sh_ftw[n] <= cfg_wdata;
                  end
               end
            end
         endcase
      end
   end

   // Commit/apply/flush/settle sequencer with registered outputs
   always_ff @(posedge sample_clk or negedge sample_rst_n) begin
      if (!sample_rst_n) begin
         r_state       <= ST_FLUSH;
         r_flush_cnt   <= FLUSH_LOAD;
         r_settle_cnt  <= 8'd0;
         r_pend_req    <= 1'b0;
         r_from_commit <= 1'b0;
         r_ftw         <= '0;
         r_cic_period  <= CIC_PERIOD_INIT;
         r_cic_shift   <= CIC_SHIFT_INIT;
         r_iir_shift   <= IIR_SHIFT_INIT;
         r_dsp_rst     <= 1'b1;
         r_meas_valid  <= 1'b0;
         r_commit_cnt  <= 8'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_commit || r_pend_req) begin
                  r_state    <= ST_PEND;
                  r_pend_req <= 1'b0;
               end
            end
            ST_PEND: begin
               // Further commits here are absorbed; only the frame boundary matters
               if (result_strobe) begin
                  for (int n = 0; n < N_CH; n++) begin
                     r_ftw[32*n +: 32] <= r_sh_ftw[n];
                  end
                  r_cic_period  <= r_sh_period;
                  r_cic_shift   <= r_sh_cic_shift;
                  r_iir_shift   <= r_sh_iir_shift;
                  r_dsp_rst     <= 1'b1;
                  r_flush_cnt   <= FLUSH_LOAD;
                  r_meas_valid  <= 1'b0;
                  r_from_commit <= 1'b1;
                  r_state       <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (w_commit) begin
                  r_pend_req <= 1'b1;
               end
               if (r_flush_cnt == 4'd0) begin
                  r_dsp_rst    <= 1'b0;
                  r_settle_cnt <= SETTLE_LOAD;
                  r_state      <= ST_SETTLE;
               end else begin
                  r_flush_cnt <= r_flush_cnt - 4'd1;
               end
            end
            ST_SETTLE: begin
               // A new commit outranks a coincident final strobe
               if (w_commit || r_pend_req) begin
                  r_state    <= ST_PEND;
                  r_pend_req <= 1'b0;
               end else if (result_strobe) begin
                  r_settle_cnt <= r_settle_cnt - 8'd1;
                  if (r_settle_cnt == 8'd1) begin
                     r_state      <= ST_IDLE;
                     r_meas_valid <= 1'b1;
                     if (r_from_commit) begin
                        r_commit_cnt <= r_commit_cnt + 8'd1;
                     end
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ftw        = r_ftw;
   assign cic_period = r_cic_period;
   assign cic_shift  = r_cic_shift;
   assign iir_shift  = r_iir_shift;
   assign dsp_rst    = r_dsp_rst;
   assign meas_valid = r_meas_valid;
   assign commit_cnt = r_commit_cnt;
   assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_vvm_cfg_sched.sv
// Scoreboard bench for vvm_cfg_sched: the stimulus side predicts apply and settle events,
// a monitor pops them when the DUT raises dsp_rst or meas_valid.
module tb_vvm_cfg_sched;

   localparam int RST_CYC  = 2;
   localparam int N_SETTLE = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          cfg_we = 1'b0;
   logic [2:0]    cfg_addr = 3'd0;
   logic [31:0]   cfg_wdata = 32'd0;
   logic          result_strobe = 1'b0;
   logic [127:0]  ftw;
   logic [12:0]   cic_period;
   logic [3:0]    cic_shift;
   logic [5:0]    iir_shift;
   logic          dsp_rst, busy, meas_valid;
   logic [7:0]    commit_cnt;

   vvm_cfg_sched #(.N_CH(4), .RST_CYC(RST_CYC), .N_SETTLE(N_SETTLE)) dut (
      .sample_clk(clk), .sample_rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .result_strobe(result_strobe), .ftw(ftw),
      .cic_period(cic_period), .cic_shift(cic_shift), .iir_shift(iir_shift),
      .dsp_rst(dsp_rst), .busy(busy), .meas_valid(meas_valid), .commit_cnt(commit_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           is_meas;
      logic [150:0] cfg;
      logic [7:0]   cnt;
   } ev_t;

   ev_t          sb_q[$];
   int           vectors = 0;
   int           miscompares = 0;

   logic [31:0]  m_ftw [4];
   logic [12:0]  m_per;
   logic [3:0]   m_cs;
   logic [5:0]   m_is;
   int           commits = 0;
   bit           rnd_wr = 1'b0;

   logic [150:0] dut_cfg;
   assign dut_cfg = {ftw, cic_period, cic_shift, iir_shift};

   function automatic logic [150:0] init_cfg();
      return {128'd0, 13'd10, 4'd7, 6'd4};
   endfunction

   function automatic logic [150:0] m_cfg();
      return {m_ftw[3], m_ftw[2], m_ftw[1], m_ftw[0], m_per, m_cs, m_is};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_ftw[i] = 32'd0;
      m_per = 13'd10; m_cs = 4'd7; m_is = 6'd4;
      commits = 0;
   endtask

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One bus cycle; expected events are pushed before the shadow model sees this cycle's write
   task automatic cyc(input bit we, input logic [2:0] a, input logic [31:0] d, input bit st,
                      input bit p_apply, input bit p_meas, input bit incr);
      ev_t ev;
      @(negedge clk);
      cfg_we = we; cfg_addr = a; cfg_wdata = d; result_strobe = st;
      if (p_apply) begin
         ev.is_meas = 1'b0; ev.cfg = m_cfg(); ev.cnt = 8'd0;
         sb_q.push_back(ev);
      end
      if (p_meas) begin
         if (incr) commits++;
         ev.is_meas = 1'b1; ev.cfg = '0; ev.cnt = 8'(commits);
         sb_q.push_back(ev);
      end
      if (we) begin
         case (a)
            3'd0, 3'd1, 3'd2, 3'd3: m_ftw[a[1:0]] = d;
            3'd4: m_per = d[12:0];
            3'd5: m_cs = d[3:0];
            3'd6: m_is = d[5:0];
            default: ;
         endcase
      end
   endtask

   task automatic wcyc(input bit st, input bit p_apply, input bit p_meas, input bit incr);
      if (rnd_wr && ($urandom_range(0, 1) == 1))
         cyc(1'b1, 3'($urandom_range(0, 6)), $urandom, st, p_apply, p_meas, incr);
      else
         cyc(1'b0, 3'd0, 32'd0, st, p_apply, p_meas, incr);
   endtask

   task automatic gap(input int n);
      repeat (n) wcyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic commit(input bit st);
      cyc(1'b1, 3'd7, $urandom, st, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic flush_cycles(input int n, input int commit_slot);
      for (int i = 0; i < n; i++) begin
         if (i == commit_slot) commit(1'($urandom_range(0, 1)));
         else wcyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic settle(input int abort_at, input bit incr, output bit aborted);
      aborted = 1'b0;
      for (int k = 0; k < N_SETTLE; k++) begin
         gap($urandom_range(0, 3));
         if (k == abort_at) begin
            commit(1'($urandom_range(0, 1)));
            aborted = 1'b1;
            break;
         end
         wcyc(1'b1, 1'b0, k == N_SETTLE - 1, incr);
      end
   endtask

   task automatic txn(input int n_wr, input int extra, input int abort_at,
                      input bit flush_commit, input bit st_with_commit);
      bit aborted;
      bit done;
      int ab;
      bit fc;
      ab = abort_at; fc = flush_commit; done = 1'b0;
      repeat (n_wr) cyc(1'b1, 3'($urandom_range(0, 6)), $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
      commit(st_with_commit);
      repeat (extra) begin
         gap($urandom_range(0, 2));
         commit(1'b0);
      end
      while (!done) begin
         gap($urandom_range(0, 2));
         wcyc(1'b1, 1'b1, 1'b0, 1'b0);
         flush_cycles(RST_CYC, fc ? int'($urandom_range(0, RST_CYC - 1)) : -1);
         if (fc) begin
            fc = 1'b0;
            cyc(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         end else begin
            settle(ab, 1'b1, aborted);
            if (aborted) ab = -1;
            else done = 1'b1;
         end
      end
      gap(2);
   endtask

   task automatic recover();
      bit aborted;
      flush_cycles(RST_CYC - 1, -1);
      settle(-1, 1'b0, aborted);
      gap(2);
   endtask

   // Monitor: pops expected events on dsp_rst/meas_valid rising and checks timing rules
   logic         prev_dsp = 1'b1, prev_meas = 1'b0;
   int           settle_n = 0, hi_n = 0;
   bit           armed = 1'b0;
   bit           mon_st, mon_cm;
   logic [150:0] exp_cfg = {128'd0, 13'd10, 4'd7, 6'd4};
   ev_t          mev;

   always @(posedge clk) begin
      mon_st = result_strobe;
      mon_cm = cfg_we && (cfg_addr == 3'd7);
      #1;
      if (!rst_n) begin
         exp_cfg = init_cfg(); prev_dsp = 1'b1; prev_meas = 1'b0;
         settle_n = 0; hi_n = 0; armed = 1'b0;
      end else begin
         if (!prev_dsp && mon_st) settle_n++;
         if (dsp_rst && !prev_dsp) begin
            settle_n = 0; armed = 1'b1; hi_n = 1;
            if (sb_q.size() == 0) begin
               chk("apply_unexpected", 160'd1, 160'd0);
            end else begin
               mev = sb_q.pop_front();
               chk("apply_ev_type", mev.is_meas, 1'b0);
               if (!mev.is_meas) exp_cfg = mev.cfg;
               chk("apply_meas_clr", meas_valid, 1'b0);
            end
         end else if (dsp_rst) begin
            hi_n++;
         end else if (prev_dsp) begin
            settle_n = 0;
            if (armed) chk("dsp_rst_len", hi_n, RST_CYC);
            armed = 1'b0;
         end
         if (meas_valid && !prev_meas) begin
            if (sb_q.size() == 0) begin
               chk("meas_unexpected", 160'd1, 160'd0);
            end else begin
               mev = sb_q.pop_front();
               chk("meas_ev_type", mev.is_meas, 1'b1);
               chk("meas_commit_cnt", commit_cnt, mev.cnt);
               chk("meas_settle_strobes", settle_n, N_SETTLE);
               chk("meas_busy", busy, 1'b0);
            end
         end
         chk("active_cfg", dut_cfg, exp_cfg);
         if (mon_cm) chk("busy_after_commit", busy, 1'b1);
         prev_dsp = dsp_rst;
         prev_meas = meas_valid;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_cfg", dut_cfg, init_cfg());
      chk("rst_dsp_rst", dsp_rst, 1'b1);
      chk("rst_busy", busy, 1'b1);
      chk("rst_meas", meas_valid, 1'b0);
      chk("rst_cnt", commit_cnt, 8'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      recover();
      chk("rel_cnt", commit_cnt, 8'd0);
      chk("rel_meas", meas_valid, 1'b1);

      rnd_wr = 1'b0;
      cyc(1'b1, 3'd2, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 3'd4, 32'd100, 1'b0, 1'b0, 1'b0, 1'b0);
      txn(0, 0, -1, 1'b0, 1'b0);
      chk("basic_ftw2", ftw[95:64], 32'h1234_5678);
      chk("basic_period", cic_period, 13'd100);
      chk("basic_cnt", commit_cnt, 8'd1);
      txn(0, 2, -1, 1'b0, 1'b0);
      chk("double_commit_cnt", commit_cnt, 8'd2);
      txn(0, 0, 2, 1'b0, 1'b0);
      chk("settle_abort_cnt", commit_cnt, 8'd3);
      txn(0, 0, -1, 1'b1, 1'b1);
      chk("flush_commit_cnt", commit_cnt, 8'd4);

      cyc(1'b1, 3'd0, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 3'd5, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      commit(1'b0);
      gap(1);
      wcyc(1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      cfg_we = 1'b0; result_strobe = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_cfg", dut_cfg, init_cfg());
      chk("midrst_dsp_rst", dsp_rst, 1'b1);
      chk("midrst_busy", busy, 1'b1);
      chk("midrst_cnt", commit_cnt, 8'd0);
      sb_q.delete();
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      recover();
      chk("midrst_rel_cnt", commit_cnt, 8'd0);

      rnd_wr = 1'b1;
      for (int t = 0; t < 258; t++) begin
         txn($urandom_range(0, 4),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, N_SETTLE - 1)) : -1,
             1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 3) == 0));
      end
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
      chk("sb_drain", sb_q.size(), 0);
      chk("wrap_cnt", commit_cnt, 8'(commits));
      chk("final_busy", busy, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vvm_cfg_sched.md
# vvm_cfg_sched

Configuration scheduler for the `vvm_dsp` datapath. Software writes LO tuning words and CIC/IIR settings into shadow registers, then issues a commit. The block applies all settings atomically on a decimated-frame boundary (`result_strobe`), pulses a datapath flush, and then masks measurements until the CIC/IIR chain has settled. It sits between the register bus and `vvm_dsp`, in the `sample_clk` domain.

## Interface

Parameters:
- `N_CH`, 4, number of LO/ADC channels.
- `RST_CYC`, 2, number of cycles `dsp_rst` is held per flush (1..15).
- `N_SETTLE`, 4, number of `result_strobe` frames discarded after a flush (1..255).
- `CIC_PERIOD_INIT`, 13'd10, reset value of `cic_period`.
- `CIC_SHIFT_INIT`, 4'd7, reset value of `cic_shift`.
- `IIR_SHIFT_INIT`, 6'd4, reset value of `iir_shift`.

Ports:
- `sample_clk`  in  1  sole clock; all logic is on its rising edge.
- `sample_rst_n`  in  1  asynchronous, active-low reset.
- `cfg_we`  in  1  shadow-register write strobe.
- `cfg_addr`  in  3  0..3: ftw ch0..3; 4: cic_period; 5: cic_shift; 6: iir_shift; 7: commit.
- `cfg_wdata`  in  32  write data, LSB-aligned; extra MSBs are ignored.
- `result_strobe`  in  1  one-cycle pulse from `vvm_dsp` marking a completed decimated frame.
- `ftw`  out  32*N_CH  active tuning words; channel n occupies bits [32n+31:32n].
- `cic_period`  out  13  active CIC decimation period.
- `cic_shift`  out  4  active CIC output shift.
- `iir_shift`  out  6  active IIR smoothing shift.
- `dsp_rst`  out  1  active-high, synchronous flush to `vvm_dsp`.
- `busy`  out  1  high in every state except IDLE.
- `meas_valid`  out  1  downstream results are settled and trustworthy.
- `commit_cnt`  out  8  count of completed commits; wraps 255→0.

## Operation

- **Shadow registers.** A write with `cfg_we`=1 and `cfg_addr`=0..6 updates the matching shadow register on that edge. Writes are accepted in every state and never touch the active outputs directly.
- **States:** IDLE, PEND, FLUSH, SETTLE.
- **IDLE.** A commit (`cfg_we`=1, `cfg_addr`=7) moves the FSM to PEND. A `result_strobe` in the same cycle does not count as the boundary.
- **PEND.** On an edge where `result_strobe`=1, the FSM does all of the following on that same edge:
  - copies every shadow register into the active outputs,
  - sets `dsp_rst`=1,
  - loads the flush counter with RST_CYC-1,
  - clears `meas_valid`,
  - enters FLUSH.
- **Extra commits in PEND** are absorbed; they cause no second apply.
- **FLUSH.** `dsp_rst` stays 1 and the counter decrements each cycle. When the counter reaches 0, `dsp_rst` goes to 0, the settle counter loads N_SETTLE, and the FSM enters SETTLE. `result_strobe` is ignored. A commit arriving in FLUSH sets a `pend_req` flag.
- **SETTLE.** Each `result_strobe` decrements the settle counter. The decrement that reaches 0 moves the FSM to IDLE, sets `meas_valid`=1 and increments `commit_cnt`.
  - A commit in SETTLE, or a set `pend_req` on SETTLE entry, aborts settling: the FSM goes to PEND, `meas_valid` stays 0 and `commit_cnt` is not incremented.
  - If a commit and the final strobe arrive in the same cycle, the commit wins.
- **IDLE from SETTLE.** If `pend_req` is set, the FSM goes to PEND on the next cycle. `pend_req` is cleared on PEND entry.
- **Reset** (asynchronous, at any time, including mid-flush):
  - `ftw`=0 and all shadow ftw registers = 0,
  - `cic_period`/`cic_shift`/`iir_shift` and their shadows take their INIT values,
  - `dsp_rst`=1, flush counter = RST_CYC-1, state = FLUSH,
  - `meas_valid`=0, `busy`=1, `commit_cnt`=0, `pend_req`=0.

  After release, the block runs FLUSH then SETTLE with no commit needed, and **does not** increment `commit_cnt`.

## Timing

- All outputs are registered; there is no combinational path from inputs to outputs.
- Commit written at edge t in IDLE: `busy`=1 from t.
- Strobe sampled at edge s in PEND: new `ftw`/`cic_*`/`iir_shift` and `dsp_rst`=1 are visible from s. `dsp_rst` falls at edge s+RST_CYC.
- Settling needs N_SETTLE strobes at edges ≥ s+RST_CYC+1. `meas_valid` rises on the edge of the N_SETTLE-th counted strobe.
- `busy` is the combinational decode of the state register (registered state, so glitch-free). It is 0 exactly when the state is IDLE.
- A shadow write and an apply in the same cycle: the apply copies the pre-write shadow value. The new value waits for the next commit.

## Test plan

- **Reset release.** Release reset, strobe every 10 cycles: `dsp_rst`=1 for 2 cycles, then 4 strobes, then `meas_valid`=1. `commit_cnt`=0, `cic_period`=10, `ftw`=0.
- **Basic commit.**
  - Write ftw ch2=0x1234_5678 and `cic_period`=100, then commit. Outputs must be unchanged until the next strobe.
  - On that strobe's edge: `ftw[95:64]`=0x12345678, `cic_period`=100, `dsp_rst` high for 2 cycles.
  - After 4 more strobes: `meas_valid`=1, `commit_cnt`=1.
- **Double commit in PEND.** Two commits in PEND: exactly one apply, `commit_cnt`=1.
- **Commit during SETTLE.** Commit after 2 settle strobes: FSM returns to PEND, `meas_valid` stays 0, apply at the next strobe. The final `commit_cnt` is incremented once.
- **Reset mid-operation.** Assert `sample_rst_n` during FLUSH after a commit: outputs return to INIT values immediately and asynchronously, with `dsp_rst`=1.
- **Counter wrap.** Run 256 commits: `commit_cnt` wraps 255→0.
